// File: rtl/mole_round_sched.sv
// Whack-a-mole round sequencer: latches an LFSR mole pattern per round, times
// shrinking show windows and fixed gaps, and scores toggles against the held mask.
module mole_round_sched #(
  parameter int NUM_ROUNDS  = 16,
  parameter int INIT_WINDOW = 200,
  parameter int MIN_WINDOW  = 40,
  parameter int WIN_STEP    = 10,
  parameter int GAP_TICKS   = 50,
  parameter int MAX_MISSES  = 8
) (
  input  logic       game_clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       start,
  input  logic [7:0] rng,
  input  logic [7:0] toggle,
  output logic [7:0] mole_mask,
  output logic [3:0] score_inc,
  output logic       miss_pulse,
  output logic [7:0] round_num,
  output logic       busy,
  output logic       game_over
);

  typedef enum logic [1:0] {IDLE, SHOW, GAP, OVER} state_t;

  state_t     state, state_nxt;
  logic [7:0] timer, timer_nxt;
  logic [7:0] window_len, window_nxt;
  logic [7:0] miss_cnt, miss_cnt_nxt;
  logic [7:0] mask_nxt, round_nxt;
  logic [3:0] score_nxt;
  logic       miss_nxt, busy_nxt, over_nxt;

  logic [7:0] hits, remaining, fresh_mask, shrunk_window;
  logic [3:0] hit_cnt;
  logic       wrong, miss_limit;

  always_comb begin
    hits       = toggle & mole_mask;
    remaining  = mole_mask & ~hits;
    wrong      = |(toggle & ~mole_mask);
    miss_limit = ({1'b0, miss_cnt} + 9'd1) >= 9'(MAX_MISSES);
    fresh_mask = (rng == 8'h00) ? 8'h01 : rng;
    hit_cnt    = 4'd0;
    for (int i = 0; i < 8; i++) hit_cnt = hit_cnt + {3'b000, hits[i]};
    // Compare before subtracting so the window can never wrap below the floor.
    shrunk_window = ({1'b0, window_len} >= 9'(MIN_WINDOW + WIN_STEP))
                    ? window_len - 8'(WIN_STEP) : 8'(MIN_WINDOW);
  end

  always_comb begin
    state_nxt    = state;
    timer_nxt    = timer;
    window_nxt   = window_len;
    miss_cnt_nxt = miss_cnt;
    mask_nxt     = mole_mask;
    round_nxt    = round_num;
    score_nxt    = 4'd0;
    miss_nxt     = 1'b0;

    case (state)
      IDLE, OVER: begin
        mask_nxt = 8'h00;
        if (start) begin
          state_nxt    = SHOW;
          round_nxt    = 8'd1;
          window_nxt   = 8'(INIT_WINDOW);
          miss_cnt_nxt = 8'd0;
          mask_nxt     = fresh_mask;
          timer_nxt    = 8'(INIT_WINDOW);
        end
      end
      SHOW: begin
        score_nxt = hit_cnt;
        mask_nxt  = remaining;
        miss_nxt  = wrong;
        if (wrong) miss_cnt_nxt = miss_cnt + 8'd1;
        if (tick) timer_nxt = timer - 8'd1;
        if (wrong && miss_limit) begin
          state_nxt = OVER;
          mask_nxt  = 8'h00;
        end else if (remaining == 8'h00 || (tick && timer == 8'd1)) begin
          state_nxt  = GAP;
          mask_nxt   = 8'h00;
          timer_nxt  = 8'(GAP_TICKS);
          window_nxt = shrunk_window;
        end
      end
      GAP: begin
        if (tick) begin
          if (timer == 8'd1) begin
            if (round_num == 8'(NUM_ROUNDS)) begin
              state_nxt = OVER;
            end else begin
              state_nxt = SHOW;
              round_nxt = round_num + 8'd1;
              mask_nxt  = fresh_mask;
              timer_nxt = window_len;
            end
          end else begin
            timer_nxt = timer - 8'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt == SHOW) || (state_nxt == GAP);
    over_nxt = (state_nxt == OVER);
  end

  always_ff @(posedge game_clk) begin
    if (rst) begin
      state      <= IDLE;
      timer      <= 8'd0;
      window_len <= 8'(INIT_WINDOW);
      miss_cnt   <= 8'd0;
      mole_mask  <= 8'h00;
      round_num  <= 8'd0;
      score_inc  <= 4'd0;
      miss_pulse <= 1'b0;
      busy       <= 1'b0;
      game_over  <= 1'b0;
    end else begin
      state      <= state_nxt;
      timer      <= timer_nxt;
      window_len <= window_nxt;
      miss_cnt   <= miss_cnt_nxt;
      mole_mask  <= mask_nxt;
      round_num  <= round_nxt;
      score_inc  <= score_nxt;
      miss_pulse <= miss_nxt;
      busy       <= busy_nxt;
      game_over  <= over_nxt;
    end
  end

endmodule
